// File: rtl/regfile_dump_ctrl_if.sv
// Write-side handshake between the register-dump controller and the data-memory arbiter.
// The controller is the master; the arbiter/memory drives mem_ready back.
interface regfile_dump_ctrl_if;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdat;
   logic        mem_ready;

   modport master (
      output mem_req,
      output mem_addr,
      output mem_wdat,
      input  mem_ready
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      input  mem_wdat,
      output mem_ready
   );
endinterface

// File: rtl/regfile_dump_ctrl.sv
// Walks the register file's second read port on a dump request and writes each word to
// data memory over a valid/ready handshake, folding the accepted words into an XOR signature.
module regfile_dump_ctrl #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_2000,
   parameter int          NUM_REGS  = 32,
   parameter bit          SKIP_X0   = 1'b0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic [4:0]                 rsel,
   input  logic [31:0]                rdat,
   regfile_dump_ctrl_if.master        mem_bus,
   output logic                       busy,
   output logic                       done,
   output logic [31:0]                signature
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [5:0] START_IDX = SKIP_X0 ? 6'd1 : 6'd0;
   localparam logic [5:0] LAST_IDX  = 6'(NUM_REGS - 1);
   // A walk whose first index is already past the last one has nothing to write.
   localparam bit         NO_WORK   = (START_IDX > LAST_IDX);

   state_t      state_r;
   state_t      state_nx_s;
   logic [5:0]  idx_r;
   logic [5:0]  idx_nx_s;
   logic [31:0] data_r;
   logic [31:0] addr_r;
   logic [31:0] addr_nx_s;
   logic [31:0] sig_r;
   logic        sig_clr_s;
   logic        sig_acc_s;

   logic [4:0]  rsel_r;
   logic        req_r;
   logic        busy_r;
   logic        done_r;
   logic [4:0]  rsel_nx_s;
   logic        req_nx_s;
   logic        busy_nx_s;
   logic        done_nx_s;

   assign addr_nx_s = BASE_ADDR + {24'h00_0000, idx_r, 2'b00};

   // Next-state and index sequencing.
   always_comb begin
      state_nx_s = state_r;
      idx_nx_s   = idx_r;
      sig_clr_s  = 1'b0;
      sig_acc_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               idx_nx_s   = START_IDX;
               sig_clr_s  = 1'b1;
               state_nx_s = NO_WORK ? ST_DONE : ST_READ;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_READ: begin
            state_nx_s = ST_WRITE;
         end
         ST_WRITE: begin
            if (mem_bus.mem_ready) begin
               sig_acc_s = 1'b1;
               if (idx_r == LAST_IDX) begin
                  state_nx_s = ST_DONE;
               end else begin
                  idx_nx_s   = idx_r + 6'd1;
                  state_nx_s = ST_READ;
               end
            end else begin
               state_nx_s = ST_WRITE;
            end
         end
         ST_DONE: begin
            if (start) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // Outputs are decoded from the next state so they can be registered without a cycle of lag.
   always_comb begin
      rsel_nx_s = 5'd0;
      req_nx_s  = 1'b0;
      busy_nx_s = 1'b0;
      done_nx_s = 1'b0;
      case (state_nx_s)
         ST_IDLE: begin
            rsel_nx_s = 5'd0;
         end
         ST_READ: begin
            rsel_nx_s = idx_nx_s[4:0];
            busy_nx_s = 1'b1;
         end
         ST_WRITE: begin
            rsel_nx_s = idx_nx_s[4:0];
            req_nx_s  = 1'b1;
            busy_nx_s = 1'b1;
         end
         ST_DONE: begin
            done_nx_s = 1'b1;
         end
         default: begin
            rsel_nx_s = 5'd0;
         end
      endcase
   end

   // State, index and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= ST_IDLE;
         idx_r   <= 6'd0;
         rsel_r  <= 5'd0;
         req_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         idx_r   <= idx_nx_s;
         rsel_r  <= rsel_nx_s;
         req_r   <= req_nx_s;
         busy_r  <= busy_nx_s;
         done_r  <= done_nx_s;
      end
   end

   // Capture the word and its slot address during the single READ cycle; held through WRITE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_r <= 32'h0000_0000;
         addr_r <= 32'h0000_0000;
      end else if (state_r == ST_READ) begin
         data_r <= rdat;
         addr_r <= addr_nx_s;
      end else begin
         data_r <= data_r;
         addr_r <= addr_r;
      end
   end

   // Signature clears on a new dump and folds in each word exactly once, at acceptance.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sig_r <= 32'h0000_0000;
      end else if (sig_clr_s) begin
         sig_r <= 32'h0000_0000;
      end else if (sig_acc_s) begin
         sig_r <= sig_r ^ data_r;
      end else begin
         sig_r <= sig_r;
      end
   end

   assign rsel             = rsel_r;
   assign busy             = busy_r;
   assign done             = done_r;
   assign signature        = sig_r;
   assign mem_bus.mem_req  = req_r;
   assign mem_bus.mem_addr = addr_r;
   assign mem_bus.mem_wdat = data_r;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// Directed bench for regfile_dump_ctrl: full dump, stalled dump, SKIP_X0, mid-dump reset,
// start held in DONE, and the single-register configurations.
module tb_regfile_dump_ctrl;

   logic clk;
   logic rst;
   logic start_drv;
   logic ready_drv;
   int   sel;
   int   n_chk;
   int   n_err;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];

   regfile_dump_ctrl_if bus_a ();
   regfile_dump_ctrl_if bus_b ();
   regfile_dump_ctrl_if bus_c ();
   regfile_dump_ctrl_if bus_d ();

   logic [4:0]  rsel_v [4];
   logic [31:0] rdat_v [4];
   logic        start_v[4];
   logic        busy_v [4];
   logic        done_v [4];
   logic [31:0] sig_v  [4];
   logic        req_v  [4];
   logic [31:0] addr_v [4];
   logic [31:0] wdat_v [4];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register-file model: r0 hardwired to zero, ri = 0x1000_0000 + i.
   for (genvar g = 0; g < 4; g++) begin : g_rf
      assign rdat_v[g]  = (rsel_v[g] == 5'd0) ? 32'h0000_0000 : (32'h1000_0000 | {27'h0, rsel_v[g]});
      assign start_v[g] = start_drv && (sel == g);
   end

   assign bus_a.mem_ready = ready_drv && (sel == 0);
   assign bus_b.mem_ready = ready_drv && (sel == 1);
   assign bus_c.mem_ready = ready_drv && (sel == 2);
   assign bus_d.mem_ready = ready_drv && (sel == 3);
   assign req_v[0] = bus_a.mem_req;  assign addr_v[0] = bus_a.mem_addr;  assign wdat_v[0] = bus_a.mem_wdat;
   assign req_v[1] = bus_b.mem_req;  assign addr_v[1] = bus_b.mem_addr;  assign wdat_v[1] = bus_b.mem_wdat;
   assign req_v[2] = bus_c.mem_req;  assign addr_v[2] = bus_c.mem_addr;  assign wdat_v[2] = bus_c.mem_wdat;
   assign req_v[3] = bus_d.mem_req;  assign addr_v[3] = bus_d.mem_addr;  assign wdat_v[3] = bus_d.mem_wdat;

   regfile_dump_ctrl dut_a (
      .clk(clk), .rst(rst), .start(start_v[0]), .rsel(rsel_v[0]), .rdat(rdat_v[0]),
      .mem_bus(bus_a), .busy(busy_v[0]), .done(done_v[0]), .signature(sig_v[0])
   );

   regfile_dump_ctrl #(.SKIP_X0(1'b1)) dut_b (
      .clk(clk), .rst(rst), .start(start_v[1]), .rsel(rsel_v[1]), .rdat(rdat_v[1]),
      .mem_bus(bus_b), .busy(busy_v[1]), .done(done_v[1]), .signature(sig_v[1])
   );

   regfile_dump_ctrl #(.NUM_REGS(1)) dut_c (
      .clk(clk), .rst(rst), .start(start_v[2]), .rsel(rsel_v[2]), .rdat(rdat_v[2]),
      .mem_bus(bus_c), .busy(busy_v[2]), .done(done_v[2]), .signature(sig_v[2])
   );

   regfile_dump_ctrl #(.NUM_REGS(1), .SKIP_X0(1'b1)) dut_d (
      .clk(clk), .rst(rst), .start(start_v[3]), .rsel(rsel_v[3]), .rdat(rdat_v[3]),
      .mem_bus(bus_d), .busy(busy_v[3]), .done(done_v[3]), .signature(sig_v[3])
   );

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one dump on the selected DUT (start already high), logging accepted writes.
   // Samples and drives at the falling edge so nothing races the DUT's rising edge.
   task automatic collect(input bit drop_start, input bit stall5, output int lat);
      int cyc;
      int t_busy;
      int stall_cnt;
      bit seen_done;
      cyc = 0; t_busy = -1; stall_cnt = 0; seen_done = 1'b0; lat = -1;
      wa_q.delete();
      wd_q.delete();
      while (cyc < 300 && !seen_done) begin
         @(negedge clk);
         cyc++;
         if (drop_start && cyc == 3) start_drv = 1'b0;
         if (busy_v[sel] && t_busy < 0) t_busy = cyc;
         if (stall5 && req_v[sel] && addr_v[sel] == 32'h0000_2014 && stall_cnt < 3) begin
            ready_drv = 1'b0;
            stall_cnt++;
            check_val("stall_req", {31'h0, req_v[sel]}, 32'h0000_0001);
            check_val("stall_addr", addr_v[sel], 32'h0000_2014);
            check_val("stall_wdat", wdat_v[sel], 32'h1000_0005);
         end else begin
            ready_drv = 1'b1;
         end
         if (req_v[sel] && ready_drv) begin
            wa_q.push_back(addr_v[sel]);
            wd_q.push_back(wdat_v[sel]);
         end
         if (done_v[sel]) begin
            seen_done = 1'b1;
            lat = cyc - t_busy;
         end
      end
      check_val("done_reached", {31'h0, seen_done}, 32'h0000_0001);
      if (drop_start) start_drv = 1'b0;
   endtask

   task automatic check_writes(input string tag, input int first_reg, input int count);
      check_val({tag, "_count"}, 32'(wa_q.size()), 32'(count));
      for (int i = 0; i < wa_q.size() && i < count; i++) begin
         check_val({tag, "_addr"}, wa_q[i], 32'h0000_2000 + 32'((first_reg + i) * 4));
         check_val({tag, "_data"}, wd_q[i], (first_reg + i == 0) ? 32'h0000_0000 : 32'h1000_0000 + 32'(first_reg + i));
      end
   endtask

   initial begin
      int lat;
      bit hit;
      n_chk = 0; n_err = 0;
      sel = 0; start_drv = 1'b0; ready_drv = 1'b1; rst = 1'b1;
      repeat (3) @(negedge clk);
      check_val("rst_rsel", {27'h0, rsel_v[0]}, 32'h0);
      check_val("rst_req", {31'h0, req_v[0]}, 32'h0);
      check_val("rst_addr", addr_v[0], 32'h0);
      check_val("rst_wdat", wdat_v[0], 32'h0);
      check_val("rst_busy", {31'h0, busy_v[0]}, 32'h0);
      check_val("rst_done", {31'h0, done_v[0]}, 32'h0);
      check_val("rst_sig", sig_v[0], 32'h0);
      rst = 1'b0;

      // Full dump, ready tied high; XOR of r0..r31 is 0x1000_0000.
      @(negedge clk); start_drv = 1'b1;
      collect(1'b1, 1'b0, lat);
      check_writes("full", 0, 32);
      check_val("full_lat", 32'(lat), 32'd64);
      check_val("full_sig", sig_v[0], 32'h1000_0000);

      // Stall three cycles on the r5 write.
      @(negedge clk); @(negedge clk); start_drv = 1'b1;
      collect(1'b1, 1'b1, lat);
      check_writes("stall", 0, 32);
      check_val("stall_lat", 32'(lat), 32'd67);
      check_val("stall_sig", sig_v[0], 32'h1000_0000);

      // SKIP_X0 instance.
      @(negedge clk); sel = 1; start_drv = 1'b1;
      collect(1'b1, 1'b0, lat);
      check_writes("skip", 1, 31);
      check_val("skip_lat", 32'(lat), 32'd62);
      check_val("skip_sig", sig_v[1], 32'h1000_0000);

      // Reset during the r10 write.
      @(negedge clk); sel = 0; start_drv = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 100 && !hit; c++) begin
         @(negedge clk);
         if (c == 2) start_drv = 1'b0;
         if (req_v[0] && addr_v[0] == 32'h0000_2028) hit = 1'b1;
      end
      check_val("r10_reached", {31'h0, hit}, 32'h0000_0001);
      #2 rst = 1'b1;
      #1;
      check_val("arst_req", {31'h0, req_v[0]}, 32'h0);
      check_val("arst_busy", {31'h0, busy_v[0]}, 32'h0);
      check_val("arst_sig", sig_v[0], 32'h0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk); start_drv = 1'b1;
      collect(1'b1, 1'b0, lat);
      check_writes("after_rst", 0, 32);

      // Hold start through DONE.
      @(negedge clk); start_drv = 1'b1;
      collect(1'b0, 1'b0, lat);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check_val("hold_done", {31'h0, done_v[0]}, 32'h1);
         check_val("hold_req", {31'h0, req_v[0]}, 32'h0);
      end
      start_drv = 1'b0;
      @(negedge clk);
      check_val("idle_done", {31'h0, done_v[0]}, 32'h0);
      check_val("idle_busy", {31'h0, busy_v[0]}, 32'h0);
      check_val("idle_sig_hold", sig_v[0], 32'h1000_0000);
      start_drv = 1'b1;
      @(negedge clk);
      check_val("restart_busy", {31'h0, busy_v[0]}, 32'h1);
      check_val("restart_sig_clr", sig_v[0], 32'h0);
      collect(1'b1, 1'b0, lat);
      check_writes("restart", 0, 32);
      check_val("restart_sig", sig_v[0], 32'h1000_0000);

      // NUM_REGS=1: a single write of r0.
      @(negedge clk); sel = 2; start_drv = 1'b1;
      collect(1'b1, 1'b0, lat);
      check_writes("one", 0, 1);
      check_val("one_done", {31'h0, done_v[2]}, 32'h1);
      check_val("one_sig", sig_v[2], 32'h0);

      // NUM_REGS=1 with SKIP_X0: straight to DONE, no write.
      @(negedge clk); sel = 3; start_drv = 1'b1;
      collect(1'b1, 1'b0, lat);
      check_val("none_count", 32'(wa_q.size()), 32'd0);
      check_val("none_busy", {31'h0, busy_v[3]}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/regfile_dump_ctrl.md
Name: regfile_dump_ctrl

Overview:
- Sequential reader for the 32x32 register file. On a halt/dump request it walks the file's read-port select 0..N-1, captures each word and writes it to data memory through a valid/ready write handshake.
- Sits between the register file's second read port (muxed in during halt) and the data-memory arbiter.
- Used for end-of-test register dumps and bench comparison. Also produces a running XOR signature of the dumped words.

Parameters:
- BASE_ADDR, 32'h0000_2000, byte address of register 0's dump slot; register i goes to BASE_ADDR + 4*i.
- NUM_REGS, 32, number of registers dumped (1..32).
- SKIP_X0, 0, when 1 register 0 is not written; the walk starts at index 1.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  level request to dump; sampled in IDLE
- rsel  out  5  register-file read select
- rdat  in  32  register-file read data (combinational from rsel)
- mem_req  out  1  write request valid
- mem_addr  out  32  byte write address
- mem_wdat  out  32  write data
- mem_ready  in  1  memory accepts the write on a clock edge where mem_req && mem_ready
- busy  out  1  high in READ/WRITE
- done  out  1  high in DONE
- signature  out  32  XOR of all words accepted in the current dump

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; idx=0; data reg=0.
  - rsel=0, mem_req=0, mem_addr=0, mem_wdat=0, busy=0, done=0, signature=0.
- State IDLE:
  - busy=0, done=0, rsel=0.
  - If start=1: idx loads (SKIP_X0 ? 1 : 0), signature clears to 0, next=READ.
- State READ (exactly 1 cycle):
  - rsel=idx.
  - At the edge, data reg <= rdat and mem_addr reg <= BASE_ADDR + (idx<<2), computed at 32 bits with wrap-around.
  - next=WRITE.
- State WRITE:
  - mem_req=1. mem_addr and mem_wdat come from registers and stay stable until accepted.
  - rsel holds idx.
  - On an edge with mem_ready=1:
    - signature <= signature ^ data.
    - If idx==NUM_REGS-1, next=DONE.
    - Else idx<=idx+1, next=READ.
  - Without mem_ready: stay in WRITE, all outputs held.
- State DONE:
  - done=1, mem_req=0, rsel=0.
  - Stays in DONE while start=1. Returns to IDLE on the first edge with start=0.
  - signature holds its final value until the next dump starts.
- Latency: 2 cycles per register with mem_ready tied high. A full 32-register dump takes 64 cycles from the first READ to DONE; 62 cycles with SKIP_X0=1.
- start is ignored outside IDLE and DONE. Deasserting start mid-dump does not abort it.
- Register 0 reads whatever the file returns; the file hardwires 0 there, so expect 0.
- Boundaries:
  - NUM_REGS=1 with SKIP_X0=0 performs one write, then DONE.
  - NUM_REGS=1 with SKIP_X0=1 is illegal. Guard it: go directly to DONE with no write.
  - mem_ready high outside WRITE is ignored.
  - mem_ready held high across states does not double-count a word.
  - rst asserted mid-WRITE drops mem_req immediately (asynchronously) and discards the partial dump.
- idx is 6 bits internally, so the compare with NUM_REGS-1 has no overflow. rsel is idx[4:0].

Test Plan:
- Preload r1..r31 = 32'h1000_0000+i, mem_ready=1, pulse start high for 3 cycles:
  - 32 writes, addr 0x2000..0x207C, data r0=0, r_i as loaded.
  - done asserts 64 cycles after first READ; signature = XOR of all 32 words.
- Same preload with mem_ready low 3 cycles on the write of r5:
  - mem_req, mem_addr=0x2014 and mem_wdat=0x1000_0005 held stable for the stall.
  - No duplicate write; signature unchanged versus the no-stall run.
- SKIP_X0=1:
  - First write addr 0x2004, 31 writes total, done after 62 cycles.
- Assert rst during WRITE of r10:
  - mem_req=0, busy=0 and signature=0 immediately.
  - A new start produces a full dump beginning at addr 0x2000.
- Hold start high after DONE:
  - done stays 1, no further mem_req.
  - Drop start: IDLE next cycle, done=0.
  - Re-raise start: a new dump runs and signature clears first.
- NUM_REGS=1, SKIP_X0=0:
  - A single write to BASE_ADDR with data 0, then done=1.
